// File: rtl/timer_pkg.sv
// Shared constants for the Avalon interval timer: register addresses,
// CTRL/STATUS bit positions and the default bus width.
package timer_pkg;

    localparam int DATA_W_DEFAULT = 32;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PERIOD   = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_COUNT    = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_COMPARE  = 3'd5;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_CONT = 1;
    localparam int CTRL_IE   = 2;

    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider for the interval timer: presc_cnt runs 0..PRESCALE while
// enabled and produces a one-clock tick on the wrap cycle.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_clear,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_presc_cnt;
    logic                  w_wrap;

    assign w_wrap = (r_presc_cnt == i_prescale);
    assign o_tick = i_enable & w_wrap;

    // Clear has priority so a fresh start always begins a full prescale window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
        end else if (i_clear) begin
            r_presc_cnt <= '0;
        end else if (i_enable) begin
            r_presc_cnt <= w_wrap ? '0 : r_presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/avalon_interval_timer.sv
// Avalon-MM interval timer: prescaled down-counter with level IRQ and a
// one-cycle timeout strobe. Optional PWM output/COMPARE register under TIMER_PWM_EN.
module avalon_interval_timer
    import timer_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int PRESCALE_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              irq,
    output logic              timeout_pulse
`ifdef TIMER_PWM_EN
    ,
    output logic              pwm_out
`endif
);

    logic [2:0]            r_ctrl;
    logic [DATA_W-1:0]     r_period;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [DATA_W-1:0]     r_count;
    logic                  r_to;
    logic [DATA_W-1:0]     r_readdata;
    logic                  r_timeout_pulse;

    logic                  w_run;
    logic                  w_cont;
    logic                  w_ctrl_wr;
    logic                  w_status_wr;
    logic                  w_wr_run1;
    logic                  w_tick;
    logic                  w_expire;
    logic                  w_start;
    logic [DATA_W-1:0]     w_rd_mux;

    assign w_run       = r_ctrl[CTRL_RUN];
    assign w_cont      = r_ctrl[CTRL_CONT];
    assign w_ctrl_wr   = avs_write && (avs_address == ADDR_CTRL);
    assign w_status_wr = avs_write && (avs_address == ADDR_STATUS);
    assign w_wr_run1   = w_ctrl_wr && avs_writedata[CTRL_RUN];
    assign w_expire    = w_tick && (r_count == '0);
    // A reload happens on RUN 0->1, and also when a RUN=1 write lands on the
    // same cycle a one-shot expiry would otherwise stop the timer.
    assign w_start     = w_wr_run1 && (!w_run || (w_expire && !w_cont));

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (reset_n),
        .i_enable   (w_run),
        .i_clear    (w_start),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= '0;
        end else if (w_ctrl_wr) begin
            r_ctrl <= avs_writedata[2:0];
        end else if (w_expire && !w_cont) begin
            r_ctrl[CTRL_RUN] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period   <= '0;
            r_prescale <= '0;
        end else if (avs_write) begin
            if (avs_address == ADDR_PERIOD) begin
                r_period <= avs_writedata;
            end
            if (avs_address == ADDR_PRESCALE) begin
                r_prescale <= avs_writedata[PRESCALE_W-1:0];
            end
        end
    end

    // One-shot expiry leaves count at 0; continuous expiry reloads PERIOD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= r_period;
        end else if (w_expire) begin
            if (w_cont) begin
                r_count <= r_period;
            end
        end else if (w_tick) begin
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to            <= 1'b0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_expire;
            if (w_expire) begin
                r_to <= 1'b1;
            end else if (w_status_wr && avs_writedata[STAT_TO]) begin
                r_to <= 1'b0;
            end
        end
    end

`ifdef TIMER_PWM_EN
    logic [DATA_W-1:0] r_compare;
    logic              r_pwm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_compare <= '0;
            r_pwm     <= 1'b0;
        end else begin
            if (avs_write && (avs_address == ADDR_COMPARE)) begin
                r_compare <= avs_writedata;
            end
            r_pwm <= w_run & (r_count < r_compare);
        end
    end

    assign pwm_out = r_pwm;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            ADDR_CTRL:     w_rd_mux[2:0] = r_ctrl;
            ADDR_PERIOD:   w_rd_mux = r_period;
            ADDR_PRESCALE: w_rd_mux[PRESCALE_W-1:0] = r_prescale;
            ADDR_COUNT:    w_rd_mux = r_count;
            ADDR_STATUS: begin
                w_rd_mux[STAT_TO]  = r_to;
                w_rd_mux[STAT_RUN] = w_run;
            end
`ifdef TIMER_PWM_EN
            ADDR_COMPARE:  w_rd_mux = r_compare;
`endif
            default:       w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign avs_readdata  = r_readdata;
    assign timeout_pulse = r_timeout_pulse;
    assign irq           = r_to & r_ctrl[CTRL_IE];

endmodule
